mul_arbiter: RTL



---
 rtl/mul_arbiter_if.sv | 27 ++
 rtl/mul_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter_if.sv
// Requester handshake and multiplier register-bus signals for mul_arbiter.
// The arbiter uses the slave modport; requesters and the multiplier side use master.
interface mul_arbiter_if #(
  parameter int NUM_REQ = 2
) ();
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] op_a;
  logic [32*NUM_REQ-1:0] op_b;
  logic [NUM_REQ-1:0]    done;
  logic [63:0]           result;
  logic                  err;
  logic [7:0]            mul_address;
  logic [31:0]           mul_write_data;
  logic                  mul_we;
  logic                  mul_re;
  logic [31:0]           mul_read_data;

  modport slave (
    input  req, op_a, op_b, mul_read_data,
    output done, result, err, mul_address, mul_write_data, mul_we, mul_re
  );

  modport master (
    output req, op_a, op_b, mul_read_data,
    input  done, result, err, mul_address, mul_write_data, mul_we, mul_re
  );
endinterface

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one sequential 32x32 multiplier among NUM_REQ requesters.
// Define MUL_ARB_TIMEOUT_EN to abort a poll that stays busy for POLL_TIMEOUT cycles.
module mul_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int POLL_TIMEOUT = 63
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_arbiter_if.slave  bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [7:0] ADDR_INFO = 8'h00;
  localparam logic [7:0] ADDR_MUL1 = 8'h04;
  localparam logic [7:0] ADDR_MUL2 = 8'h08;
  localparam logic [7:0] ADDR_RESH = 8'h0C;
  localparam logic [7:0] ADDR_RESL = 8'h10;

  if (NUM_REQ < 1 || NUM_REQ > 8 || POLL_TIMEOUT <= 32 || POLL_TIMEOUT > 127) begin : g_param_check
    $error("mul_arbiter: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_WA, S_WB, S_POLL, S_RDH, S_RDL, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, grant_q, grant_d, pick_s;
  logic [31:0]          b_q, b_d, res_hi_q, res_hi_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [63:0]          result_q, result_d;
  logic                 err_q, err_d;
  logic [7:0]           addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic                 we_q, we_d, re_q, re_d;
  logic                 found_s, timeout_s;

  // First requesting index at or after the round-robin pointer, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      logic [IDX_W-1:0] cand;
      logic             hit;
      cand    = (int'(ptr_q) + i >= NUM_REQ) ? IDX_W'(int'(ptr_q) + i - NUM_REQ)
                                             : IDX_W'(int'(ptr_q) + i);
      hit     = !found_s && bus.req[cand];
      pick_s  = hit ? cand : pick_s;
      found_s = found_s | hit;
    end
  end

`ifdef MUL_ARB_TIMEOUT_EN
  logic [6:0] cnt_q, cnt_d;

  // Poll-cycle counter: zero outside POLL, so it starts at zero on POLL entry.
  always_comb begin
    cnt_d = (state_q == S_POLL) ? cnt_q + 7'd1 : 7'd0;
  end

  // Poll-cycle counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 7'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = (state_q == S_POLL) && bus.mul_read_data[0] &&
                     (cnt_q == 7'(POLL_TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next-state, grant/pointer and operand/result-high capture.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    b_d      = b_q;
    res_hi_d = res_hi_q;
    case (state_q)
      S_IDLE: begin
        if (found_s) begin
          state_d = S_WA;
          grant_d = pick_s;
          b_d     = bus.op_b[32*int'(pick_s) +: 32];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WA:   state_d = S_WB;
      S_WB:   state_d = S_POLL;
      S_POLL: begin
        if (timeout_s) begin
          state_d = S_DONE;
        end else if (!bus.mul_read_data[0]) begin
          state_d = S_RDH;
        end else begin
          state_d = S_POLL;
        end
      end
      S_RDH: begin
        res_hi_d = bus.mul_read_data;
        state_d  = S_RDL;
      end
      S_RDL:  state_d = S_DONE;
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the upcoming state; the write-data
  // register doubles as the latch for operand a during WA.
  always_comb begin
    we_d     = 1'b0;
    re_d     = 1'b0;
    addr_d   = 8'h00;
    wdata_d  = 32'h0;
    done_d   = '0;
    result_d = result_q;
    err_d    = err_q;
    case (state_d)
      S_WA: begin
        we_d    = 1'b1;
        addr_d  = ADDR_MUL1;
        wdata_d = bus.op_a[32*int'(pick_s) +: 32];
      end
      S_WB: begin
        we_d    = 1'b1;
        addr_d  = ADDR_MUL2;
        wdata_d = b_q;
      end
      S_POLL: begin
        re_d   = 1'b1;
        addr_d = ADDR_INFO;
      end
      S_RDH: begin
        re_d   = 1'b1;
        addr_d = ADDR_RESH;
      end
      S_RDL: begin
        re_d   = 1'b1;
        addr_d = ADDR_RESL;
      end
      S_DONE: begin
        done_d   = NUM_REQ'(1) << grant_q;
        err_d    = timeout_s;
        result_d = timeout_s ? 64'h0 : {res_hi_q, bus.mul_read_data};
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      grant_q  <= '0;
      b_q      <= 32'h0;
      res_hi_q <= 32'h0;
      done_q   <= '0;
      result_q <= 64'h0;
      err_q    <= 1'b0;
      addr_q   <= 8'h00;
      wdata_q  <= 32'h0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      b_q      <= b_d;
      res_hi_q <= res_hi_d;
      done_q   <= done_d;
      result_q <= result_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      re_q     <= re_d;
    end
  end

  assign bus.done           = done_q;
  assign bus.result         = result_q;
  assign bus.err            = err_q;
  assign bus.mul_address    = addr_q;
  assign bus.mul_write_data = wdata_q;
  assign bus.mul_we         = we_q;
  assign bus.mul_re         = re_q;
endmodule
